// File: rtl/mmio_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder_if
// Brief    : Request/response bundle between the LSU uncachable IO path and
//            the MMIO responder (initiator = master, responder = slave).
// Revision : 1.0 - initial release
// ============================================================================
interface mmio_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [28:0] reqAddr;   // {isUncachable, isIO, addr[26:0]}
    logic [31:0] reqWData;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspData;
    logic        rspError;

    modport master (
        output reqValid, reqWrite, reqAddr, reqWData, rspReady,
        input  reqReady, rspValid, rspData, rspError
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWData, rspReady,
        output reqReady, rspValid, rspData, rspError
    );
endinterface
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Brief    : IO-region target: mtime/mtimecmp timer, serial byte FIFO and
//            gaze register. Gaze register present only with RSD_MMIO_GAZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_responder #(
    parameter int TIMER_DIV         = 1,
    parameter int SERIAL_FIFO_DEPTH = 8
) (
    input  wire               clk,
    input  wire               rst,
    mmio_responder_if.slave   bus,
    output logic              serialValid,
    output logic [7:0]        serialData,
    input  wire               serialReady,
    output logic [31:0]       gazeAddr,
    output logic              timerIrq
);

    localparam int c_addrW = (SERIAL_FIFO_DEPTH > 1) ? $clog2(SERIAL_FIFO_DEPTH) : 1;
    localparam int c_divW  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

    localparam logic [c_divW-1:0]  c_divLast  = c_divW'(TIMER_DIV - 1);
    localparam logic [c_divW-1:0]  c_divOne   = c_divW'(1);
    localparam logic [c_addrW:0]   c_depthCnt = (c_addrW + 1)'(SERIAL_FIFO_DEPTH);
    localparam logic [c_addrW:0]   c_ptrOne   = (c_addrW + 1)'(1);

    // Word-address decode (raw addr[26:2])
    localparam logic [24:0] c_wMtimeLo = 25'h000_0000;
    localparam logic [24:0] c_wMtimeHi = 25'h000_0001;
    localparam logic [24:0] c_wCmpLo   = 25'h000_0002;
    localparam logic [24:0] c_wCmpHi   = 25'h000_0003;
    localparam logic [24:0] c_wSerial  = 25'h100_0000;
    localparam logic [24:0] c_wGaze    = 25'h100_0001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWAIT = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e            r_state;
    state_e            w_stateNext;

    logic [63:0]       r_mtime;
    logic [63:0]       r_mtimeCmp;
    logic [c_divW-1:0] r_divCnt;
    logic              r_timerIrq;
    logic [31:0]       r_rspData;
    logic              r_rspError;
    logic [7:0]        r_pendByte;

    logic [7:0]        r_fifoMem [SERIAL_FIFO_DEPTH];
    logic [c_addrW:0]  r_wrPtr;
    logic [c_addrW:0]  r_rdPtr;

    logic [26:0]       w_rawAddr;
    logic [24:0]       w_word;
    logic              w_isIO;
    logic              w_selMtimeLo;
    logic              w_selMtimeHi;
    logic              w_selCmpLo;
    logic              w_selCmpHi;
    logic              w_selSerial;
    logic              w_selGaze;
    logic              w_mapped;
    logic [31:0]       w_rdData;
    logic              w_accept;
    logic              w_wrEn;
    logic              w_push;
    logic [7:0]        w_pushData;
    logic              w_pop;
    logic [c_addrW:0]  w_fifoCount;
    logic              w_fifoFull;
    logic              w_fifoEmpty;
    logic              w_tick;
    logic              w_unusedBits;

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    assign w_rawAddr    = bus.reqAddr[26:0];
    assign w_isIO       = bus.reqAddr[27];
    assign w_word       = w_rawAddr[26:2];
    assign w_unusedBits = &{1'b0, bus.reqAddr[28], w_rawAddr[1:0]};

    assign w_selMtimeLo = w_isIO && (w_word == c_wMtimeLo);
    assign w_selMtimeHi = w_isIO && (w_word == c_wMtimeHi);
    assign w_selCmpLo   = w_isIO && (w_word == c_wCmpLo);
    assign w_selCmpHi   = w_isIO && (w_word == c_wCmpHi);
    assign w_selSerial  = w_isIO && (w_word == c_wSerial);

`ifdef RSD_MMIO_GAZE_EN
    logic [31:0] r_gaze;

    assign w_selGaze = w_isIO && (w_word == c_wGaze);
    assign gazeAddr  = r_gaze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gaze <= 32'h0;
        end else if (w_wrEn && w_selGaze) begin
            r_gaze <= bus.reqWData;
        end
    end
`else
    assign w_selGaze = 1'b0;
    assign gazeAddr  = 32'h0;
`endif

    assign w_mapped = w_selMtimeLo | w_selMtimeHi | w_selCmpLo | w_selCmpHi
                    | w_selSerial  | w_selGaze;

    always_comb begin
        w_rdData = 32'h0;
        if (w_selMtimeLo) w_rdData = r_mtime[31:0];
        if (w_selMtimeHi) w_rdData = r_mtime[63:32];
        if (w_selCmpLo)   w_rdData = r_mtimeCmp[31:0];
        if (w_selCmpHi)   w_rdData = r_mtimeCmp[63:32];
        if (w_selSerial)  w_rdData = 32'(w_fifoCount);
        if (w_selGaze)    w_rdData = gazeAddr;
    end

    // ------------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_push      = 1'b0;
        w_pushData  = r_pendByte;
        case (r_state)
            IDLE: begin
                if (bus.reqValid) begin
                    w_accept = 1'b1;
                    if (bus.reqWrite && w_selSerial && w_fifoFull) begin
                        w_stateNext = SWAIT;
                    end else begin
                        w_stateNext = RESP;
                        if (bus.reqWrite && w_selSerial) begin
                            w_push     = 1'b1;
                            w_pushData = bus.reqWData[7:0];
                        end
                    end
                end
            end
            SWAIT: begin
                // A pop this cycle frees the head slot, so the push can land now.
                if (!w_fifoFull || w_pop) begin
                    w_push      = 1'b1;
                    w_stateNext = RESP;
                end
            end
            RESP: begin
                if (bus.rspReady) begin
                    w_stateNext = IDLE;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    assign w_wrEn       = w_accept && bus.reqWrite;
    assign bus.reqReady = (r_state == IDLE);
    assign bus.rspValid = (r_state == RESP);
    assign bus.rspData  = r_rspData;
    assign bus.rspError = r_rspError;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rspData  <= 32'h0;
            r_rspError <= 1'b0;
            r_pendByte <= 8'h0;
        end else if (w_accept) begin
            r_rspData  <= bus.reqWrite ? 32'h0 : w_rdData;
            r_rspError <= !w_mapped;
            r_pendByte <= bus.reqWData[7:0];
        end
    end

    // ------------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------------
    assign w_tick   = (r_divCnt == c_divLast);
    assign timerIrq = r_timerIrq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_divCnt   <= '0;
            r_mtime    <= 64'h0;
            r_mtimeCmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_timerIrq <= 1'b0;
        end else begin
            r_divCnt   <= w_tick ? '0 : (r_divCnt + c_divOne);
            r_timerIrq <= (r_mtime >= r_mtimeCmp);
            // A half-write overrides the tick entirely; no carry into the other half.
            if (w_wrEn && w_selMtimeLo) begin
                r_mtime <= {r_mtime[63:32], bus.reqWData};
            end else if (w_wrEn && w_selMtimeHi) begin
                r_mtime <= {bus.reqWData, r_mtime[31:0]};
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wrEn && w_selCmpLo) r_mtimeCmp[31:0]  <= bus.reqWData;
            if (w_wrEn && w_selCmpHi) r_mtimeCmp[63:32] <= bus.reqWData;
        end
    end

    // ------------------------------------------------------------------------
    // Serial FIFO
    // ------------------------------------------------------------------------
    assign w_fifoCount = r_wrPtr - r_rdPtr;
    assign w_fifoFull  = (w_fifoCount == c_depthCnt);
    assign w_fifoEmpty = (w_fifoCount == '0);
    assign serialValid = !w_fifoEmpty;
    assign serialData  = w_fifoEmpty ? 8'h0 : r_fifoMem[r_rdPtr[c_addrW-1:0]];
    assign w_pop       = serialValid && serialReady;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_ptrOne;
            if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr[c_addrW-1:0]] <= w_pushData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Brief    : Self-checking bench for mmio_responder (scoreboard of responses,
//            cycle-level mtime model). Honours RSD_MMIO_GAZE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_responder;

    localparam int          TIMER_DIV = 1;
    localparam int          DEPTH     = 8;
    localparam logic [26:0] A_SERIAL  = 27'h400_0000;
    localparam logic [26:0] A_GAZE    = 27'h400_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        serialReady = 1'b0;
    logic        serialValid;
    logic [7:0]  serialData;
    logic [31:0] gazeAddr;
    logic        timerIrq;

    mmio_responder_if bus ();

    mmio_responder #(
        .TIMER_DIV         (TIMER_DIV),
        .SERIAL_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .serialValid (serialValid),
        .serialData  (serialData),
        .serialReady (serialReady),
        .gazeAddr    (gazeAddr),
        .timerIrq    (timerIrq)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] sb[$];            // {rspError, rspData}

    // mtime reference: one increment per cycle, half-writes replace the tick
    logic [63:0] mMtime;
    logic        mWrLo  = 1'b0;
    logic        mWrHi  = 1'b0;
    logic [31:0] mWData = 32'h0;

    always @(posedge clk or posedge rst) begin
        if (rst)        mMtime <= 64'h0;
        else if (mWrLo) mMtime <= {mMtime[63:32], mWData};
        else if (mWrHi) mMtime <= {mWData, mMtime[31:0]};
        else            mMtime <= mMtime + 64'd1;
    end

    function automatic logic [28:0] ioA(input logic [26:0] a);
        return {2'b11, a};
    endfunction

    task automatic doReset();
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqAddr  = '0;
        bus.reqWData = '0;
        bus.rspReady = 1'b0;
        serialReady  = 1'b0;
        mWrLo        = 1'b0;
        mWrHi        = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    // Presents one request and returns 1 time unit after the accepting edge.
    task automatic sendReq(input logic wr, input logic [28:0] addr, input logic [31:0] wd,
                           input logic [31:0] expD, input logic expE, input logic useTimer);
        logic [31:0] d;
        bit          done;
        d    = expD;
        done = 1'b0;
        @(negedge clk);
        bus.reqValid = 1'b1;
        bus.reqWrite = wr;
        bus.reqAddr  = addr;
        bus.reqWData = wd;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.reqReady === 1'b1) begin
                if (useTimer) d = addr[2] ? mMtime[63:32] : mMtime[31:0];
                if (wr && addr[27] && addr[26:3] == '0) begin
                    mWData = wd;
                    if (addr[2]) mWrHi = 1'b1;
                    else         mWrLo = 1'b1;
                end
                @(posedge clk);
                #1;
                mWrLo        = 1'b0;
                mWrHi        = 1'b0;
                bus.reqValid = 1'b0;
                sb.push_back({expE, d});
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout addr=%h reqReady=%b required=1", addr, bus.reqReady);
            bus.reqValid = 1'b0;
        end
    endtask

    task automatic getRsp(input string name);
        bit          done;
        logic [32:0] e;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.rspValid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s unexpected response got err=%b data=%h required none",
                             name, bus.rspError, bus.rspData);
                end else begin
                    e = sb.pop_front();
                    if ({bus.rspError, bus.rspData} !== e) begin
                        bad++;
                        $display("FAIL %s got err=%b data=%h required err=%b data=%h",
                                 name, bus.rspError, bus.rspData, e[32], e[31:0]);
                    end
                end
                bus.rspReady = 1'b1;
                @(posedge clk);
                #1 bus.rspReady = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL %s rsp_timeout rspValid=%b required=1", name, bus.rspValid);
        end
    endtask

    task automatic test_reset();
        doReset();
        total++;
        if ({bus.reqReady, bus.rspValid, bus.rspError, serialValid, timerIrq} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_flags got rdy/vld/err/ser/irq=%b required 10000",
                     {bus.reqReady, bus.rspValid, bus.rspError, serialValid, timerIrq});
        end
        total++;
        if (bus.rspData !== 32'h0 || serialData !== 8'h0 || gazeAddr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got rspData=%h serialData=%h gaze=%h required 0",
                     bus.rspData, serialData, gazeAddr);
        end
        sendReq(1'b0, ioA(27'h0), 32'h0, 32'h0, 1'b0, 1'b0);
        total++;
        if (bus.rspValid !== 1'b1) begin
            bad++;
            $display("FAIL first_latency got rspValid=%b required 1", bus.rspValid);
        end
        getRsp("mtime_lo_at_reset");
    endtask

    task automatic test_timer_count();
        doReset();
        repeat (10) @(posedge clk);
        sendReq(1'b0, ioA(27'h0), 32'h0, 32'h0, 1'b0, 1'b1);
        getRsp("mtime_lo_count");
        sendReq(1'b0, ioA(27'h4), 32'h0, 32'h0, 1'b0, 1'b0);
        getRsp("mtime_hi_count");
    endtask

    task automatic test_irq();
        bit hit;
        doReset();
        sendReq(1'b1, ioA(27'h8), 32'd20, 32'h0, 1'b0, 1'b0);
        getRsp("cmp_lo_write");
        sendReq(1'b1, ioA(27'hC), 32'd0, 32'h0, 1'b0, 1'b0);
        getRsp("cmp_hi_write");
        sendReq(1'b0, ioA(27'h8), 32'h0, 32'd20, 1'b0, 1'b0);
        getRsp("cmp_lo_read");
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            if (mMtime == 64'd20) hit = 1'b1;
        end
        total++;
        if (!hit || timerIrq !== 1'b0) begin
            bad++;
            $display("FAIL irq_at_match got irq=%b reached=%b required irq=0 reached=1", timerIrq, hit);
        end
        @(negedge clk);
        total++;
        if (timerIrq !== 1'b1) begin
            bad++;
            $display("FAIL irq_one_after got irq=%b required 1", timerIrq);
        end
    endtask

    task automatic test_wrap();
        doReset();
        sendReq(1'b1, ioA(27'h0), 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        getRsp("mtime_lo_write");
        sendReq(1'b0, ioA(27'h4), 32'h0, 32'd1, 1'b0, 1'b0);
        getRsp("mtime_hi_carry");
        sendReq(1'b0, ioA(27'h0), 32'h0, 32'h0, 1'b0, 1'b1);
        getRsp("mtime_lo_wrapped");
    endtask

    task automatic fillFifo();
        for (int i = 0; i < DEPTH; i++) begin
            sendReq(1'b1, ioA(A_SERIAL), 32'h41 + i, 32'h0, 1'b0, 1'b0);
            getRsp("serial_push");
        end
    endtask

    task automatic test_serial();
        logic [7:0] b;
        doReset();
        fillFifo();
        total++;
        if (serialValid !== 1'b1 || serialData !== 8'h41) begin
            bad++;
            $display("FAIL serial_head got vld=%b data=%h required 1/41", serialValid, serialData);
        end
        sendReq(1'b1, ioA(A_SERIAL), 32'h49, 32'h0, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.reqReady !== 1'b0 || bus.rspValid !== 1'b0) begin
                bad++;
                $display("FAIL swait_stall got reqReady=%b rspValid=%b required 0/0",
                         bus.reqReady, bus.rspValid);
            end
        end
        serialReady = 1'b1;
        @(posedge clk);
        #1 serialReady = 1'b0;
        total++;
        if (serialData !== 8'h42 || bus.rspValid !== 1'b1) begin
            bad++;
            $display("FAIL swait_release got head=%h rspValid=%b required 42/1", serialData, bus.rspValid);
        end
        getRsp("serial_stalled_rsp");
        sendReq(1'b0, ioA(A_SERIAL), 32'h0, 32'd8, 1'b0, 1'b0);
        getRsp("serial_occupancy");
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(8'h42 + i);
            @(negedge clk);
            total++;
            if (serialValid !== 1'b1 || serialData !== b) begin
                bad++;
                $display("FAIL serial_drain got vld=%b data=%h required 1/%h", serialValid, serialData, b);
            end
            serialReady = 1'b1;
            @(posedge clk);
            #1 serialReady = 1'b0;
        end
        @(negedge clk);
        total++;
        if (serialValid !== 1'b0 || serialData !== 8'h0) begin
            bad++;
            $display("FAIL serial_empty got vld=%b data=%h required 0/00", serialValid, serialData);
        end
    endtask

    task automatic test_gaze();
        doReset();
`ifdef RSD_MMIO_GAZE_EN
        sendReq(1'b1, ioA(A_GAZE), 32'h8000_1234, 32'h0, 1'b0, 1'b0);
        total++;
        if (gazeAddr !== 32'h8000_1234) begin
            bad++;
            $display("FAIL gaze_reg got %h required 80001234", gazeAddr);
        end
        getRsp("gaze_write");
        sendReq(1'b0, ioA(A_GAZE), 32'h0, 32'h8000_1234, 1'b0, 1'b0);
        getRsp("gaze_read");
`else
        sendReq(1'b1, ioA(A_GAZE), 32'h8000_1234, 32'h0, 1'b1, 1'b0);
        total++;
        if (gazeAddr !== 32'h0) begin
            bad++;
            $display("FAIL gaze_tied got %h required 00000000", gazeAddr);
        end
        getRsp("gaze_write_unmapped");
        sendReq(1'b0, ioA(A_GAZE), 32'h0, 32'h0, 1'b1, 1'b0);
        getRsp("gaze_read_unmapped");
`endif
    endtask

    task automatic test_errors();
        doReset();
        sendReq(1'b0, ioA(27'h123_4560), 32'h0, 32'h0, 1'b1, 1'b0);
        getRsp("unmapped_read");
        sendReq(1'b0, ioA(27'h10), 32'h0, 32'h0, 1'b1, 1'b0);
        getRsp("unmapped_past_cmp");
        sendReq(1'b1, {2'b10, 27'h0}, 32'h55, 32'h0, 1'b1, 1'b0);
        getRsp("non_io_write");
        sendReq(1'b0, {2'b10, 27'h0}, 32'h0, 32'h0, 1'b1, 1'b0);
        getRsp("non_io_read");
        sendReq(1'b0, ioA(27'h0), 32'h0, 32'h0, 1'b0, 1'b1);
        getRsp("timer_unchanged");
    endtask

    task automatic test_hold();
        logic [32:0] e;
        doReset();
        sendReq(1'b0, ioA(27'h0), 32'h0, 32'h0, 1'b0, 1'b1);
        e = sb[0];
        repeat (5) begin
            @(negedge clk);
            total++;
            if (bus.rspValid !== 1'b1 || bus.reqReady !== 1'b0 || bus.rspData !== e[31:0]) begin
                bad++;
                $display("FAIL rsp_hold got vld=%b rdy=%b data=%h required 1/0/%h",
                         bus.rspValid, bus.reqReady, bus.rspData, e[31:0]);
            end
        end
        getRsp("rsp_after_hold");
    endtask

    task automatic test_reset_in_swait();
        doReset();
        fillFifo();
        sendReq(1'b1, ioA(A_SERIAL), 32'h49, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({bus.reqReady, bus.rspValid, bus.rspError, serialValid, timerIrq} !== 5'b10000 ||
            bus.rspData !== 32'h0 || serialData !== 8'h0 || gazeAddr !== 32'h0) begin
            bad++;
            $display("FAIL swait_reset got rdy/vld/err/ser/irq=%b data=%h ser=%h gaze=%h required 10000/0/0/0",
                     {bus.reqReady, bus.rspValid, bus.rspError, serialValid, timerIrq},
                     bus.rspData, serialData, gazeAddr);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        sendReq(1'b0, ioA(A_SERIAL), 32'h0, 32'h0, 1'b0, 1'b0);
        getRsp("fifo_empty_after_reset");
    endtask

    initial begin
        test_reset();
        test_timer_count();
        test_irq();
        test_wrap();
        test_serial();
        test_gaze();
        test_errors();
        test_hold();
        test_reset_in_swait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Target-side responder for the physical IO region; serves requests whose physical address has isIO=1.
- Contains the timer (mtime/mtimecmp), a serial-output byte FIFO and the gaze address register.
- Sits behind the load/store unit's uncachable IO path: the initiator sends a translated PhyAddrPath, and this block decodes the raw address and returns a response.

Parameters:
- TIMER_DIV, 1: clk cycles per mtime increment (≥1).
- SERIAL_FIFO_DEPTH, 8: serial byte FIFO entries (power of 2, ≥2).

Ports:
- clk in 1: clock
- rst in 1: asynchronous active-high reset
- reqValid in 1: request valid
- reqReady out 1: block can accept a request
- reqWrite in 1: 1=store, 0=load
- reqAddr in 29: PhyAddrPath {isUncachable, isIO, addr[26:0]}
- reqWData in 32: store data
- rspValid out 1: response valid
- rspReady in 1: initiator accepts response
- rspData out 32: load data (0 for stores)
- rspError out 1: unmapped or non-IO access
- serialValid out 1: FIFO non-empty
- serialData out 8: FIFO head byte
- serialReady in 1: consumer pops the head byte
- gazeAddr out 32: gaze register value
- timerIrq out 1: mtime >= mtimecmp, unsigned 64-bit compare

Behaviour:
- Reset values:
  - FSM=IDLE, reqReady=1, rspValid=0, rspData=0, rspError=0.
  - FIFO empty (serialValid=0, serialData=0).
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, timerIrq=0, gazeAddr=0, divider counter=0.
- Decode uses raw addr, word accesses only; addr[1:0] is ignored.
  - 0x000_0000 mtime[31:0]; 0x000_0004 mtime[63:32]; 0x000_0008 mtimecmp[31:0]; 0x000_000C mtimecmp[63:32].
  - 0x400_0000 serial: a write pushes reqWData[7:0]; a read returns the FIFO occupancy, zero-extended.
  - 0x400_0004 gaze: a write loads gazeAddr; a read returns it.
  - Any other raw address, or isIO=0: rspError=1, rspData=0, no state change.
- FSM states IDLE, SWAIT, RESP:
  - IDLE: reqReady=1. On reqValid, latch the request.
    - A serial write with the FIFO full goes to SWAIT.
    - Any other request is performed and the block goes to RESP.
  - SWAIT: reqReady=0. Stays until the FIFO has a free entry, then pushes and goes to RESP. A pop and a push in the same cycle when full is allowed: the push happens in that cycle.
  - RESP: rspValid=1, rspData/rspError stable. When rspReady=1, returns to IDLE.
  - Minimum latency: request accepted at cycle N, rspValid asserted at N+1. Throughput is 1 request per 2 cycles.
  - reqReady=0 in SWAIT and RESP; a request presented then is held by the initiator.
- Load data is sampled in the accept cycle, i.e. the mtime value before that cycle's increment.
- Timer:
  - The divider counts 0..TIMER_DIV-1; at terminal count, mtime increments by 1 with 64-bit wrap (all-ones becomes 0).
  - A write to an mtime half in the same cycle as an increment: the write wins for the written half; the other half keeps its old value (no carry applied that cycle).
  - timerIrq is registered: it reflects the compare of the previous cycle's mtime/mtimecmp values.
- FIFO:
  - Circular with read/write pointers plus one extra wrap bit.
  - Full when occupancy == SERIAL_FIFO_DEPTH; empty when 0.
  - The head is popped when serialValid && serialReady.
  - serialData is the head entry; it is 0 when empty.
- Reset mid-operation: all state returns to reset values immediately. A pending response and the FIFO contents are discarded.

Optional Feature:
- Macro: RSD_MMIO_GAZE_EN.
- Defined: the gaze register exists as described above.
- Undefined: 0x400_0004 decodes as unmapped (rspError=1), and gazeAddr is tied to 0.

Test Plan:
- Reset, then read raw 0x000_0000 immediately -> rspValid next cycle, rspData=0, rspError=0; with TIMER_DIV=1, a read 10 cycles later returns 10 ± FSM offset, exact value checked against a model.
- Write mtimecmp_lo=20, mtimecmp_hi=0 with mtime counting from 0 -> timerIrq rises exactly 1 cycle after mtime reaches 20. Write mtime_lo=0xFFFF_FFFF -> the next increment gives mtime_lo=0 and mtime_hi+1.
- 9 serial writes (0x41..0x49) with serialReady=0, DEPTH=8 -> 8 responses complete; the 9th stalls in SWAIT with reqReady=0. Pulse serialReady -> 0x41 popped, 0x49 pushed, response issued. A serial read then returns 8.
- Write gaze 0x8000_1234 -> gazeAddr=0x8000_1234 next cycle; read returns it. With RSD_MMIO_GAZE_EN undefined -> rspError=1, gazeAddr=0.
- Access raw 0x123_4560, and access 0x000_0000 with isIO=0 -> both give rspError=1, rspData=0, timer unchanged.
- Hold rspReady=0 for 5 cycles -> rspValid and rspData stable and reqReady=0 throughout. Assert rst while in SWAIT -> all outputs at reset values and the FIFO empty.
